// File: rtl/rr_arbiter_4.sv
// rr_arbiter_4: four-requester round-robin arbiter feeding a 2-to-4 decoder.
// Grants one requester at a time, holds the grant until the owner strobes
// `done` or drops its request, and presents the winner as a registered
// 2-bit index qualified by `gnt_valid`.
// Optional feature macro: RR_ARBITER_4_TIMEOUT_EN -- when defined, a grant held
// for MAX_HOLD cycles is forcibly released and `timeout` pulses for one cycle.
// When undefined, no hold counter is built and `timeout` is tied to 0.
module rr_arbiter_4 #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       done,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    // MAX_HOLD is only meaningful in 2..255; reject anything else at elaboration.
    generate
        if ((MAX_HOLD < 2) || (MAX_HOLD > 255)) begin : g_bad_max_hold
            $error("rr_arbiter_4: MAX_HOLD must be in 2..255");
        end
    endgenerate

    // Round-robin search: first set request strictly after `last`, wrapping
    // mod 4, so the previous winner gets the lowest priority.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] l);
        logic [1:0] idx;
        logic       found;
        rr_pick = l + 2'd1;
        found   = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idx = l + 2'(i);
            if (!found && r[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    logic [0:0] state_q, state_d;
    logic [1:0] last_q, last_d;
    logic [1:0] gnt_idx_q, gnt_idx_d;
    logic       gnt_valid_q, gnt_valid_d;
    logic       release_s;

`ifdef RR_ARBITER_4_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
    logic [7:0] hold_q, hold_d;
    logic       timeout_q, timeout_d;
`endif

    // The owner releases by strobing done or by withdrawing its own request.
    assign release_s = done | ~req[gnt_idx_q];

    // Next-state logic: arbitrate only in IDLE, watch for release in GRANT.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;
`ifdef RR_ARBITER_4_TIMEOUT_EN
        hold_d      = hold_q;
        timeout_d   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req != 4'b0000) begin
                    gnt_idx_d   = rr_pick(req, last_q);
                    gnt_valid_d = 1'b1;
                    state_d     = ST_GRANT;
`ifdef RR_ARBITER_4_TIMEOUT_EN
                    hold_d      = 8'd0;
`endif
                end else begin
                    state_d     = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (release_s) begin
                    gnt_valid_d = 1'b0;
                    last_d      = gnt_idx_q;
                    state_d     = ST_IDLE;
                end
`ifdef RR_ARBITER_4_TIMEOUT_EN
                else if (hold_q == HOLD_LAST) begin
                    // Forced release; a same-cycle done takes the branch above.
                    gnt_valid_d = 1'b0;
                    last_d      = gnt_idx_q;
                    state_d     = ST_IDLE;
                    timeout_d   = 1'b1;
                end else begin
                    hold_d      = hold_q + 8'd1;
                end
`else
                else begin
                    state_d     = ST_GRANT;
                end
`endif
            end
            default: begin
                state_d     = ST_IDLE;
                gnt_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            last_q      <= 2'd3;
            gnt_idx_q   <= 2'd0;
            gnt_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
        end
    end

`ifdef RR_ARBITER_4_TIMEOUT_EN
    // Hold counter and timeout pulse register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q    <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;

endmodule

// File: doc/rr_arbiter_4.md
# rr_arbiter_4

Four-requester round-robin arbiter that sits directly upstream of the 2-to-4 decoder stage. It grants one requester at a time, holds the grant until the owner releases it, and presents the winner as a 2-bit binary index with a valid flag. The downstream decoder turns the index into a one-hot enable, qualified by `gnt_valid`.

## Interface
- `MAX_HOLD`, default 16: maximum cycles a grant may be held when the timeout feature is compiled in; legal range 2..255.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `req` in 4: request lines; `req[k]` high means requester k wants the resource.
- `done` in 1: single-cycle release strobe from the current owner.
- `gnt_idx` out 2: registered index of the granted requester; feeds the decoder input.
- `gnt_valid` out 1: registered; high while `gnt_idx` names a live grant.
- `timeout` out 1: registered single-cycle pulse on a forced release. Tied to 0 when the feature is compiled out.

## Operation
- FSM has two states: IDLE and GRANT. Reset state is IDLE.
- Priority pointer `last[1:0]` holds the most recently granted index. Reset value is 3, so requester 0 has top priority after reset.
- **IDLE:**
  - If `req` is nonzero, search from `last+1` upward, modulo 4, and take the first set bit.
  - Register the winner into `gnt_idx`, set `gnt_valid`=1, and go to GRANT.
  - If `req` is 0, stay in IDLE. `gnt_idx` holds its previous value.
- **GRANT:** the grant is released when either condition is true in a cycle:
  - `done`=1, or
  - `req[gnt_idx]`=0 (the requester withdraws).
- **On release:**
  - Clear `gnt_valid`.
  - Load `last` with `gnt_idx`.
  - Go to IDLE. `gnt_idx` holds its value.
- `done` and a withdrawal in the same cycle count as one release.
- `done` in IDLE is ignored.
- Changes on other `req` bits during GRANT have no effect on the current grant.
- Hold counter is 8 bits. It clears on entry to GRANT and increments each cycle in GRANT.
- Reset values:
  - `gnt_idx`=0, `gnt_valid`=0, `timeout`=0
  - `last`=3, state=IDLE, hold counter=0

## Timing
- Grant latency: a request sampled at edge N with the arbiter in IDLE gives `gnt_valid`=1 after edge N. That is one cycle from request to grant.
- Release latency: `done` sampled at edge M gives `gnt_valid`=0 after edge M.
- Back-to-back grants always have at least one cycle with `gnt_valid`=0, because arbitration happens only in IDLE. The next grant appears after edge M+1.
- `gnt_idx` is stable for the whole time `gnt_valid`=1. The decoder output is therefore glitch-free when ANDed with `gnt_valid`.
- Asserting `rst_n` low at any time, including mid-grant, forces all reset values immediately without waiting for a clock edge. After `rst_n` rises, the first arbitration is at the next rising edge.

## Configuration
- Macro: `RR_ARBITER_4_TIMEOUT_EN`.
- **Defined:**
  - When the hold counter reaches `MAX_HOLD`-1 in GRANT with no release, the arbiter forces a release on that edge.
  - The release behaves as a normal release: `last` is updated and the FSM returns to IDLE.
  - `timeout` pulses high for exactly one cycle, aligned with `gnt_valid` falling.
  - If `done` arrives on the same cycle as the forced release, it counts as a normal release and `timeout` stays 0.
- **Undefined:**
  - The hold counter and `timeout` logic are not built and `timeout` is tied to 0.
  - A grant is held indefinitely until `done` or withdrawal.

## Test plan
- Reset, then `req`=4'b0001 held: `gnt_valid`=1 and `gnt_idx`=0 one cycle later. Pulse `done`: `gnt_valid`=0 the next cycle.
- `req`=4'b1111 held, `done` pulsed one cycle after each grant: grant order is 0,1,2,3,0, with one idle cycle between grants.
- Fairness after `last`=2: `req`=4'b0101 gives a grant to 0, not 2. With `last`=0, the same request gives a grant to 2.
- Owner withdrawal: with index 1 granted, drop `req[1]` without `done`. `gnt_valid` falls one cycle later. `done` and the withdrawal together produce exactly one release.
- `rst_n` pulsed low mid-grant between clock edges: outputs go to 0 immediately. After reset, `req`=4'b1000 is granted index 3 one cycle later, and `last` is back at 3.
- With `RR_ARBITER_4_TIMEOUT_EN` defined and `MAX_HOLD`=4, `req[2]` held with no `done`: `gnt_valid` is high for 4 cycles, then falls, with `timeout` high for exactly that one cycle. With the macro undefined, the grant is held for 100 cycles and `timeout` stays 0.
